// File: rtl/cc_feeder.sv
// Four-element deserializer feeding the CC compute stage: collects four signed
// 4-bit elements and presents them as one parallel set, holding it until consumed.
module cc_feeder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic [2:0] in_opt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_n0,
  output logic [3:0] out_n1,
  output logic [3:0] out_n2,
  output logic [3:0] out_n3,
  output logic [2:0] out_opt
);

  // Handshake: an element transfers on a rising edge where in_valid && in_ready;
  // a set transfers where out_valid && out_ready. Both ready/valid outputs are
  // decoded from registers only, so no input reaches an output combinationally.
  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_cnt;
  logic       r_arm;
  logic [3:0] r_n0;
  logic [3:0] r_n1;
  logic [3:0] r_n2;
  logic [3:0] r_n3;
  logic [2:0] r_opt;
  logic       w_accept;

  // r_arm blocks acceptance on the edge that coincides with reset release.
  assign in_ready  = (r_state == S_COLLECT) && r_arm;
  assign out_valid = (r_state == S_HOLD);
  assign w_accept  = in_valid && in_ready;

  assign out_n0  = r_n0;
  assign out_n1  = r_n1;
  assign out_n2  = r_n2;
  assign out_n3  = r_n3;
  assign out_opt = r_opt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_COLLECT;
      r_cnt   <= 2'd0;
      r_arm   <= 1'b0;
      r_n0    <= 4'd0;
      r_n1    <= 4'd0;
      r_n2    <= 4'd0;
      r_n3    <= 4'd0;
      r_opt   <= 3'd0;
    end else begin
      r_arm <= 1'b1;
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            case (r_cnt)
              2'd0: begin
                r_n0  <= in_data;
                r_opt <= in_opt;
              end
              2'd1: r_n1 <= in_data;
              2'd2: r_n2 <= in_data;
              default: begin
                r_n3    <= in_data;
                r_state <= S_HOLD;
              end
            endcase
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_HOLD: begin
          if (out_ready) r_state <= S_COLLECT;
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

endmodule
